turfio_cin_tx: RTL and testbench
================================

Name: turfio_cin_tx

Overview:
TURFIO-side transmitter for the CIN command link: the opposite end of the SURF's CIN capture/parallelizer path.
- Accepts 32-bit commands over a valid/ready handshake in the aclk domain.
- Serializes each word as eight 4-bit nibbles, MSB nibble first, one nibble per clock-enable.
- Fills unused word slots with an idle word; replaces all traffic with a fixed training pattern for receiver bitslip/lock.
- Feeds the downstream 4:1 OSERDES stage. Word boundaries can be realigned by a sync pulse.

Parameters:
TRAIN_PATTERN, 32'hA55A6996, word sent in every slot while training is enabled.
IDLE_WORD, 32'h00000000, word sent when no command is pending.
CNT_WIDTH, 16, width of the accepted-command and aborted-word counters.

Ports:
aclk_i  in  1  transmit clock.
rst_i  in  1  asynchronous, active-high reset.
ce_i  in  1  nibble-advance enable (rxclk phase indicator in aclk domain).
phase_sync_i  in  1  single-cycle pulse; forces a new word boundary.
train_i  in  1  training enable, level.
command_i  in  32  command word.
command_valid_i  in  1  command valid.
command_ready_o  out  1  command accepted this cycle.
cin_o  out  4  nibble to serializer.
cin_valid_o  out  1  cin_o updated this cycle.
word_start_o  out  1  cin_o holds nibble 0 of a word.
train_active_o  out  1  current word is TRAIN_PATTERN.
cmd_count_o  out  CNT_WIDTH  accepted commands, saturating.
abort_count_o  out  CNT_WIDTH  command words truncated by phase_sync_i, saturating.

Behaviour:
State:
- 32-bit shift register sr.
- 3-bit phase counter ph.
- Flags for the current word: is_cmd, is_train.

Load slot: ce_i=1 and (ph==7 or phase_sync_i=1).

Next-word priority at a load slot:
1. train_i=1: load TRAIN_PATTERN.
2. Else command_valid_i=1: load command_i.
3. Else: load IDLE_WORD.

On a load slot:
- sr <= next word; ph <= 0.
- is_train and is_cmd updated to match the loaded word.

On ce_i=1 outside a load slot: sr <= sr<<4 (zero-filled); ph <= ph+1.

On ce_i=0: all state holds. phase_sync_i is ignored when ce_i=0 (pulse must coincide with ce_i).

Handshake:
- command_ready_o = ce_i & load_slot & ~train_i & command_valid_i. This output is combinational.
- command_i is consumed in exactly the cycle ready and valid are both high.
- No command is accepted while training.
- Back-to-back commands therefore go out every 8 ce cycles.

Outputs:
- cin_o = sr[31:28], registered.
- cin_valid_o = ce_i delayed one cycle.
- word_start_o = (ph==0) & cin_valid_o.
- train_active_o = is_train.
- Latency: command accepted in cycle N; nibble 0 appears on cin_o in cycle N+1.

train_i changes mid-word: no effect until the next load slot. A word in flight is never truncated by training.

phase_sync_i when ph!=7:
- The current word is abandoned and the next word is loaded.
- If the abandoned word was a command (is_cmd=1), abort_count_o increments.

Counters:
- cmd_count_o increments on every handshake; abort_count_o as above.
- Both saturate at all-ones.
- Simultaneous handshake and abort in the same cycle increment both counters.

Reset values:
- sr=IDLE_WORD, ph=7 (so the first ce_i is a load slot).
- cin_o=IDLE_WORD[31:28].
- cin_valid_o=0, word_start_o=0, train_active_o=0, command_ready_o=0.
- Both counters 0.

Reset mid-word: the in-flight word is lost silently and is not counted.

Decomposition:
- Shared package (turfio_cin_pkg): TRAIN_PATTERN, IDLE_WORD and NIBBLES_PER_WORD=8 constants, plus a cin_nibble_t typedef. The SURF-side parallelizer uses the same constants.
- One sub-module: turfio_sat_counter (parameterized saturating counter), instantiated twice.

Test Plan:
1. Reset, ce_i=1 constant, command_i=32'h12345678 valid -> ready in first cycle; cin_o = 1,2,3,4,5,6,7,8 over the next 8 cycles; word_start_o on nibble 1; cmd_count_o=1; IDLE nibbles 0 afterwards.
2. train_i=1 with command_valid_i held high -> command_ready_o never asserts; cin_o repeats A,5,5,A,6,9,9,6; train_active_o=1. Drop train_i mid-word -> current pattern completes, then the command is sent.
3. ce_i asserted every third cycle, command 32'hDEADBEEF -> cin_o advances only after each ce_i; cin_valid_o pulses once per ce_i; 24 cycles per word.
4. phase_sync_i on nibble 3 of command 32'hCAFEF00D, second command pending -> second command loads immediately; abort_count_o=1, cmd_count_o=2. Sync with ce_i=0 -> ignored.
5. 10 back-to-back commands, valid held -> one accept every 8 ce; no idle nibbles between words; cmd_count_o=10.
6. Assert rst_i on nibble 5 -> outputs return to reset values asynchronously; counters 0; first post-reset ce_i loads a new word.

Source files
------------

// File: rtl/turfio_cin_pkg.sv
// Constants shared by both ends of the CIN link: the TURFIO transmitter
// and the SURF-side parallelizer.
package turfio_cin_pkg;
  localparam int          NIBBLES_PER_WORD = 8;
  localparam logic [31:0] TRAIN_PATTERN    = 32'hA55A6996;
  localparam logic [31:0] IDLE_WORD        = 32'h00000000;

  typedef logic [3:0] cin_nibble_t;
endpackage

// File: rtl/turfio_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module turfio_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/turfio_cin_tx.sv
// CIN command-link transmitter: turns 32-bit commands into a nibble stream,
// MSB nibble first, one nibble per clock enable, for the 4:1 OSERDES stage.
module turfio_cin_tx
  import turfio_cin_pkg::cin_nibble_t;
  import turfio_cin_pkg::NIBBLES_PER_WORD;
#(
  parameter logic [31:0] TRAIN_PATTERN = turfio_cin_pkg::TRAIN_PATTERN,
  parameter logic [31:0] IDLE_WORD     = turfio_cin_pkg::IDLE_WORD,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                 aclk_i,
  input  logic                 rst_i,
  input  logic                 ce_i,
  input  logic                 phase_sync_i,
  input  logic                 train_i,
  input  logic [31:0]          command_i,
  input  logic                 command_valid_i,
  output logic                 command_ready_o,
  output cin_nibble_t          cin_o,
  output logic                 cin_valid_o,
  output logic                 word_start_o,
  output logic                 train_active_o,
  output logic [CNT_WIDTH-1:0] cmd_count_o,
  output logic [CNT_WIDTH-1:0] abort_count_o
);

  localparam logic [2:0] LAST_PH = 3'(NIBBLES_PER_WORD - 1);

  logic [31:0] sr;
  logic [2:0]  ph;
  logic        is_cmd;
  logic        is_train;
  logic        cin_valid_reg;

  logic        load_slot;
  logic        handshake;
  logic        abort;
  logic [31:0] next_word;

  always_comb begin
    load_slot = ce_i & ((ph == LAST_PH) | phase_sync_i);
    // A command offered during reset would be dropped, so never acknowledge it.
    handshake = load_slot & ~train_i & command_valid_i & ~rst_i;
    abort     = load_slot & (ph != LAST_PH) & is_cmd;
    next_word = IDLE_WORD;
    if (train_i) begin
      next_word = TRAIN_PATTERN;
    end else if (command_valid_i) begin
      next_word = command_i;
    end
  end

  // ph starts at the last nibble so the very first enable opens a new word.
  always_ff @(posedge aclk_i or posedge rst_i) begin
    if (rst_i) begin
      sr            <= IDLE_WORD;
      ph            <= LAST_PH;
      is_cmd        <= 1'b0;
      is_train      <= 1'b0;
      cin_valid_reg <= 1'b0;
    end else begin
      cin_valid_reg <= ce_i;
      if (load_slot) begin
        sr       <= next_word;
        ph       <= '0;
        is_cmd   <= ~train_i & command_valid_i;
        is_train <= train_i;
      end else if (ce_i) begin
        sr <= {sr[27:0], 4'h0};
        ph <= ph + 3'd1;
      end
    end
  end

  assign command_ready_o = handshake;
  assign cin_o           = sr[31:28];
  assign cin_valid_o     = cin_valid_reg;
  assign word_start_o    = (ph == '0) & cin_valid_reg;
  assign train_active_o  = is_train;

  logic [1:0]           cnt_inc;
  logic [CNT_WIDTH-1:0] cnt_val [2];

  assign cnt_inc = {abort, handshake};

  for (genvar gi = 0; gi < 2; gi++) begin : g_counter
    turfio_sat_counter #(
      .WIDTH(CNT_WIDTH)
    ) u_counter (
      .clk  (aclk_i),
      .rst  (rst_i),
      .inc  (cnt_inc[gi]),
      .count(cnt_val[gi])
    );
  end

  assign cmd_count_o   = cnt_val[0];
  assign abort_count_o = cnt_val[1];

endmodule

// File: tb/tb_turfio_cin_tx.sv
// Directed bench for turfio_cin_tx with a nibble scoreboard: each word opened
// at a load slot pushes its eight expected nibbles, each cin_valid_o pops one.
module tb_turfio_cin_tx;

  localparam logic [31:0] TP = 32'hA55A6996;

  logic        aclk;
  logic        rst_i;
  logic        ce_i;
  logic        phase_sync_i;
  logic        train_i;
  logic [31:0] command_i;
  logic        command_valid_i;
  logic        command_ready_o;
  logic [3:0]  cin_o;
  logic        cin_valid_o;
  logic        word_start_o;
  logic        train_active_o;
  logic [15:0] cmd_count_o;
  logic [15:0] abort_count_o;

  turfio_cin_tx dut (
    .aclk_i         (aclk),
    .rst_i          (rst_i),
    .ce_i           (ce_i),
    .phase_sync_i   (phase_sync_i),
    .train_i        (train_i),
    .command_i      (command_i),
    .command_valid_i(command_valid_i),
    .command_ready_o(command_ready_o),
    .cin_o          (cin_o),
    .cin_valid_o    (cin_valid_o),
    .word_start_o   (word_start_o),
    .train_active_o (train_active_o),
    .cmd_count_o    (cmd_count_o),
    .abort_count_o  (abort_count_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entries: {word_start, nibble}
  logic [4:0]  exp_q[$];
  int          m_ph;
  logic        m_is_cmd;
  logic        m_train;
  logic        m_valid;
  logic [3:0]  m_cin;
  logic [15:0] m_cmd;
  logic [15:0] m_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_ph     = 7;
    m_is_cmd = 1'b0;
    m_train  = 1'b0;
    m_valid  = 1'b0;
    m_cin    = 4'h0;
    m_cmd    = '0;
    m_abort  = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cin"},         32'(cin_o),          32'h0);
    chk({tag, "_cin_valid"},   32'(cin_valid_o),    32'h0);
    chk({tag, "_word_start"},  32'(word_start_o),   32'h0);
    chk({tag, "_train_active"},32'(train_active_o), 32'h0);
    chk({tag, "_cmd_count"},   32'(cmd_count_o),    32'h0);
    chk({tag, "_abort_count"}, 32'(abort_count_o),  32'h0);
  endtask

  task automatic do_reset();
    rst_i           = 1'b1;
    ce_i            = 1'b0;
    phase_sync_i    = 1'b0;
    train_i         = 1'b0;
    command_valid_i = 1'b0;
    command_i       = '0;
    repeat (2) @(posedge aclk);
    #1;
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("reset_ready", 32'(command_ready_o), 32'h0);
    check_reset_outputs("reset");
  endtask

  // Called shortly after a rising edge with inputs already applied.
  task automatic cycle();
    logic        load;
    logic        exp_ready;
    logic        abrt;
    logic [31:0] word;
    logic [4:0]  e;
    #1;
    load      = ce_i && ((m_ph == 7) || phase_sync_i);
    exp_ready = load && !train_i && command_valid_i;
    chk("ready", 32'(command_ready_o), 32'(exp_ready));
    if (load) begin
      abrt = (m_ph != 7) && m_is_cmd;
      word = train_i ? TP : (command_valid_i ? command_i : 32'h0);
      exp_q.delete();
      for (int k = 0; k < 8; k++) exp_q.push_back({(k == 0), word[31-4*k -: 4]});
      m_ph     = 0;
      m_is_cmd = exp_ready;
      m_train  = train_i;
      if (exp_ready && (m_cmd != 16'hFFFF)) m_cmd++;
      if (abrt && (m_abort != 16'hFFFF)) m_abort++;
    end else if (ce_i) begin
      m_ph++;
    end
    m_valid = ce_i;
    @(posedge aclk);
    #1;
    chk("cin_valid", 32'(cin_valid_o), 32'(m_valid));
    if (m_valid) begin
      n_checks++;
      assert (exp_q.size() != 0) begin
        n_pass++;
        e     = exp_q.pop_front();
        m_cin = e[3:0];
        chk("word_start", 32'(word_start_o), 32'(e[4]));
      end else $error("FAIL scoreboard_underflow observed=nibble %h expected=none", cin_o);
    end else begin
      chk("word_start_idle", 32'(word_start_o), 32'h0);
    end
    chk("cin", 32'(cin_o), 32'(m_cin));
    chk("train_active", 32'(train_active_o), 32'(m_train));
    chk("cmd_count", 32'(cmd_count_o), 32'(m_cmd));
    chk("abort_count", 32'(abort_count_o), 32'(m_abort));
  endtask

  initial begin
    rst_i = 1'b1;
    model_reset();

    // 1: single command right out of reset, then idle
    do_reset();
    ce_i = 1'b1; command_i = 32'h12345678; command_valid_i = 1'b1;
    cycle();
    command_valid_i = 1'b0;
    repeat (12) cycle();
    chk("t1_cmd_count", 32'(cmd_count_o), 32'd1);

    // 2: training blocks commands; dropping train mid-word finishes the pattern
    do_reset();
    ce_i = 1'b1; train_i = 1'b1; command_i = 32'h0BADCAFE; command_valid_i = 1'b1;
    repeat (19) cycle();
    chk("t2_train_active", 32'(train_active_o), 32'h1);
    train_i = 1'b0;
    repeat (6) cycle();
    command_valid_i = 1'b0;
    repeat (9) cycle();
    chk("t2_cmd_count", 32'(cmd_count_o), 32'd1);
    chk("t2_train_active_off", 32'(train_active_o), 32'h0);

    // 3: sparse clock enable, one enable every third cycle
    do_reset();
    command_i = 32'hDEADBEEF;
    for (int i = 0; i < 30; i++) begin
      ce_i            = (i % 3 == 0);
      command_valid_i = (i == 0);
      cycle();
    end
    chk("t3_cmd_count", 32'(cmd_count_o), 32'd1);

    // 4: phase sync on nibble 3 aborts a command; sync without ce is ignored
    do_reset();
    ce_i = 1'b1; command_i = 32'hCAFEF00D; command_valid_i = 1'b1;
    cycle();
    command_i = 32'h13579BDF;
    repeat (3) cycle();
    phase_sync_i = 1'b1;
    cycle();
    phase_sync_i = 1'b0; command_valid_i = 1'b0;
    repeat (9) cycle();
    chk("t4_abort_count", 32'(abort_count_o), 32'd1);
    chk("t4_cmd_count", 32'(cmd_count_o), 32'd2);
    repeat (3) cycle();
    ce_i = 1'b0; phase_sync_i = 1'b1;
    cycle();
    ce_i = 1'b1; phase_sync_i = 1'b0;
    repeat (6) cycle();
    phase_sync_i = 1'b1;
    cycle();
    phase_sync_i = 1'b0;
    repeat (4) cycle();
    chk("t4_abort_after_idle_sync", 32'(abort_count_o), 32'd1);

    // 5: ten back-to-back commands with valid held
    do_reset();
    ce_i = 1'b1;
    for (int i = 0; i < 88; i++) begin
      command_i       = 32'h0F1E2D3C + 32'h11111111 * 32'(m_cmd);
      command_valid_i = (m_cmd < 16'd10);
      cycle();
    end
    chk("t5_cmd_count", 32'(cmd_count_o), 32'd10);

    // 6: asynchronous reset in the middle of a word
    do_reset();
    ce_i = 1'b1; command_i = 32'h89ABCDEF; command_valid_i = 1'b1;
    cycle();
    command_valid_i = 1'b0;
    repeat (5) cycle();
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    command_valid_i = 1'b1;
    #1;
    chk("t6_ready_in_reset", 32'(command_ready_o), 32'h0);
    @(posedge aclk);
    #1;
    rst_i = 1'b0;
    model_reset();
    command_i = 32'h2468ACE0;
    cycle();
    command_valid_i = 1'b0;
    repeat (10) cycle();
    chk("t6_cmd_count", 32'(cmd_count_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
